pixel_readout: RTL

PIXEL_READOUT -- requirements
Module: pixel_readout

---
 rtl/pixel_pkg.sv | 11 +
 rtl/pixel_fifo.sv | 35 +++
 rtl/pixel_readout.sv | 85 ++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// pixel_pkg: shared state encoding, parameter defaults and FIFO entry layout for the pixel readout
package pixel_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_COL = 2;
  typedef enum logic [1:0] {IDLE, CONV, PUSH} state_t;
  typedef struct packed {
    logic first;
    logic last;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO with registered storage and a zero-latency head entry
module pixel_fifo #(
  parameter int W = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         full,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  // a write into a full FIFO is fine when the head leaves in the same cycle
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{AW{1'b0}}, do_wr};
      rd_ptr <= rd_ptr + {{AW{1'b0}}, do_rd};
    end
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/pixel_readout.sv
// pixel_readout: conversion counter, row capture and column streaming of pixel codes into an output FIFO
module pixel_readout
  import pixel_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_COL = DEF_N_COL,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    erase,
  input  logic                    expose,
  input  logic                    convert,
  input  logic                    read0,
  input  logic                    read1,
  input  logic [N_COL*DATA_W-1:0] pix_data,
  output logic [DATA_W-1:0]       cnt_out,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_first,
  output logic                    out_last,
  output logic                    overflow
);
  localparam int CW = N_COL > 1 ? $clog2(N_COL) : 1;
  state_t state;
  logic [CW-1:0] col;
  logic row_idx, r0_q, r1_q, erase_q;
  logic [DATA_W-1:0] row_q [N_COL];
  logic cap, cap1, last_col, wr, full, empty;
  logic [DATA_W+1:0] wr_entry, head;
  logic unused_expose;
  assign unused_expose = expose;
  assign cap1 = read1 & ~r1_q;
  assign cap = (read0 & ~r0_q) | cap1;
  assign last_col = col == CW'(N_COL - 1);
  assign wr = state == PUSH && !full;
  assign wr_entry = {!row_idx && col == '0, row_idx && last_col, row_q[col]};
  always_ff @(posedge clk)
    if (cap && state != PUSH)
      for (int c = 0; c < N_COL; c++) row_q[c] <= pix_data[c*DATA_W +: DATA_W];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt_out <= '0;
      col <= '0;
      row_idx <= 1'b0;
      r0_q <= 1'b0;
      r1_q <= 1'b0;
      erase_q <= 1'b0;
      overflow <= 1'b0;
    end else begin
      r0_q <= read0;
      r1_q <= read1;
      erase_q <= erase;
      cnt_out <= (state == CONV && convert) ? cnt_out + DATA_W'(cnt_out != '1) : '0;
      if (erase && !erase_q) overflow <= 1'b0;
      else if (cap && state == PUSH) overflow <= 1'b1;
      // a new row is only taken when the previous one has fully left the row register
      if (cap && state != PUSH) begin
        state <= PUSH;
        col <= '0;
        row_idx <= cap1;
      end else if (state == IDLE && convert) state <= CONV;
      else if (state == CONV && !convert) state <= IDLE;
      else if (wr) begin
        col <= last_col ? '0 : col + CW'(1);
        if (last_col) state <= IDLE;
      end
    end
  pixel_fifo #(.W(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(wr),
    .wr_data(wr_entry),
    .full(full),
    .rd_en(out_ready),
    .rd_data(head),
    .empty(empty)
  );
  assign out_valid = !empty;
  assign out_data = head[DATA_W-1:0];
  assign out_first = out_valid & head[DATA_W+1];
  assign out_last = out_valid & head[DATA_W];
endmodule
